// File: rtl/shift_rows_pipe_pkg.sv
// Shared definitions for the ShiftRows pipeline and its permutation core.
//   - legal ranges for the block width (NB) and the pipeline depth (STAGES)
//   - offset(nb, row): Rijndael row rotation amount for a given block width
//   - nb_legal / stages_legal / cfg_legal: used by instantiating modules to
//     reject unsupported parameter combinations at elaboration time
package shift_rows_pipe_pkg;

  localparam int unsigned NbMin     = 4;
  localparam int unsigned NbMax     = 8;
  localparam int unsigned StagesMin = 1;
  localparam int unsigned StagesMax = 4;

  // Bytes per column and rows per state are fixed by the cipher.
  localparam int unsigned RowCount  = 4;
  localparam int unsigned ColBits   = 32;

  typedef enum logic {
    OpFwd = 1'b0,
    OpInv = 1'b1
  } shift_op_e;

  // Row rotation: C = {0,1,2,3} for 128/192-bit blocks, {0,1,3,4} for 256-bit.
  function automatic int unsigned offset(input int unsigned nb, input int unsigned row);
    if (nb == 8 && row >= 2) begin
      return row + 1;
    end
    return row;
  endfunction

  function automatic bit nb_legal(input int unsigned nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  function automatic bit stages_legal(input int unsigned stages);
    return (stages >= StagesMin) && (stages <= StagesMax);
  endfunction

  function automatic bit cfg_legal(input int unsigned nb, input int unsigned stages);
    return nb_legal(nb) && stages_legal(stages);
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational (Inv)ShiftRows byte permutation.
// Ports:
//   inv_i  - 0: ShiftRows, 1: InvShiftRows
//   data_i - state, column-major, column 0 in the MSBs, row 0 = MSB byte of a column
//   data_o - permuted state, same layout
// Pure wiring: every output byte selects between two fixed input bytes.
module shift_rows_perm
  import shift_rows_pipe_pkg::*;
#(
  parameter int unsigned NB = 4
) (
  input  logic              inv_i,
  input  logic [32*NB-1:0]  data_i,
  output logic [32*NB-1:0]  data_o
);

  localparam int unsigned W = ColBits * NB;

  if (!nb_legal(NB)) begin : gen_nb_check
    $error("shift_rows_perm: NB must be 4, 6 or 8");
  end

  for (genvar c = 0; c < NB; c++) begin : gen_col
    for (genvar r = 0; r < RowCount; r++) begin : gen_row
      localparam int unsigned Off    = offset(NB, r);
      localparam int unsigned SrcFwd = (c + Off) % NB;
      // Adding NB before the modulo keeps the index non-negative.
      localparam int unsigned SrcInv = (c + NB - Off) % NB;
      localparam int unsigned DstPos = W - 8 - ColBits * c - 8 * r;
      localparam int unsigned FwdPos = W - 8 - ColBits * SrcFwd - 8 * r;
      localparam int unsigned InvPos = W - 8 - ColBits * SrcInv - 8 * r;

      assign data_o[DstPos +: 8] = inv_i ? data_i[InvPos +: 8] : data_i[FwdPos +: 8];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Valid/ready pipelined (Inv)ShiftRows.
// The permutation is applied combinationally in front of stage 1; later
// stages only delay the word. Each stage carries valid, data and the
// in_inv mode bit so mixed modes stay attached to their words.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   flush               - synchronous clear of every stage valid; blocks input
//   in_valid / in_ready - input handshake; in_ready does not look at in_valid
//   in_inv, in_data     - mode and state of the incoming word
//   out_valid/out_ready - output handshake
//   out_data, out_inv   - transformed state and its mode bit
module shift_rows_pipe
  import shift_rows_pipe_pkg::*;
#(
  parameter int unsigned NB     = 4,
  parameter int unsigned STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [32*NB-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic              out_inv
);

  localparam int unsigned W = ColBits * NB;

  if (!cfg_legal(NB, STAGES)) begin : gen_cfg_check
    $error("shift_rows_pipe: NB must be 4/6/8 and STAGES 1..4");
  end

  logic [W-1:0]              perm_data;
  logic                      accept;
  logic [STAGES-1:0]         advance;
  logic [STAGES-1:0]         valid_vec;
  logic [STAGES-1:0]         inv_vec;
  logic [STAGES-1:0][W-1:0]  data_vec;

  shift_rows_perm #(
    .NB (NB)
  ) u_perm (
    .inv_i  (in_inv),
    .data_i (in_data),
    .data_o (perm_data)
  );

  // advance[0] already covers the "stage 1 empty" case.
  assign in_ready = ~flush & advance[0];
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    logic          valid_q, valid_d;
    logic          inv_q, inv_d;
    logic [W-1:0]  data_q, data_d;
    logic          src_valid;
    logic          src_inv;
    logic [W-1:0]  src_data;

    if (k == 0) begin : gen_head
      assign src_valid = accept;
      assign src_inv   = in_inv;
      assign src_data  = perm_data;
    end else begin : gen_body
      assign src_valid = valid_vec[k-1];
      assign src_inv   = inv_vec[k-1];
      assign src_data  = data_vec[k-1];
    end

    // Closed form of the recursive rule: a stage moves if any stage from here
    // to the output is empty (a bubble absorbs the shift) or the sink accepts.
    assign advance[k] = out_ready | ~(&valid_vec[STAGES-1:k]);

    always_comb begin
      valid_d = valid_q;
      inv_d   = inv_q;
      data_d  = data_q;
      if (flush) begin
        valid_d = 1'b0;
      end else if (advance[k]) begin
        valid_d = src_valid;
        if (src_valid) begin
          inv_d  = src_inv;
          data_d = src_data;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        inv_q   <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        inv_q   <= inv_d;
        data_q  <= data_d;
      end
    end

    assign valid_vec[k] = valid_q;
    assign inv_vec[k]   = inv_q;
    assign data_vec[k]  = data_q;
  end

  assign out_valid = valid_vec[STAGES-1];
  assign out_inv   = inv_vec[STAGES-1];
  assign out_data  = data_vec[STAGES-1];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: instance A (NB=4, STAGES=1) for the known AES
// vectors and reset/accept timing, instance B (NB=8, STAGES=3) driven through
// a scoreboard for burst, stall, flush and mid-stream reset behaviour.
module tb_shift_rows_pipe;

  localparam int unsigned BStages = 3;

  localparam logic [127:0] VecIn  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] VecOut = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [255:0] Asc    =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         a_flush, a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv;
  logic [127:0] a_in_data, a_out_data;
  logic         b_flush, b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv;
  logic [255:0] b_in_data, b_out_data;

  shift_rows_pipe #(.NB(4), .STAGES(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_inv(a_out_inv)
  );

  shift_rows_pipe #(.NB(8), .STAGES(BStages)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_inv(b_out_inv)
  );

  typedef struct {
    logic [255:0] data;
    logic         inv;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   received = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], $urandom()};
    return r;
  endfunction

  // Reference byte permutation written from the Rijndael definition.
  function automatic logic [255:0] ref_sr(input logic [255:0] d, input int nb, input logic inv);
    logic [255:0] o = '0;
    int off, src, dpos, spos;
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        off  = (nb == 8 && r >= 2) ? r + 1 : r;
        src  = inv ? (c - off + nb) % nb : (c + off) % nb;
        dpos = nb * 32 - 8 - 32 * c - 8 * r;
        spos = nb * 32 - 8 - 32 * src - 8 * r;
        o[dpos +: 8] = d[spos +: 8];
      end
    end
    return o;
  endfunction

  task automatic wait_b(input string tag);
    int n = 0;
    while (!b_out_valid && n < 20) begin
      step();
      n++;
    end
    check(tag, b_out_valid, 1);
  endtask

  // Scoreboard monitor on B, sampled mid-cycle ahead of the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("b_in_ready", b_in_ready,
            !b_flush && !(sb.size() == BStages && !b_out_ready));
      if (b_flush) begin
        sb.delete();
      end else begin
        if (b_out_valid && b_out_ready) begin
          check("b_out_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("b_out_data", b_out_data, mon_e.data);
            check("b_out_inv", b_out_inv, mon_e.inv);
            received++;
          end
        end
        if (b_in_valid && b_in_ready) begin
          sb.push_back('{data: ref_sr(b_in_data, 8, b_in_inv), inv: b_in_inv});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  logic [255:0] words[10];
  logic [255:0] y;
  int           sent, cyc, rx_base, n;
  logic         acc;

  initial begin
    a_flush = 0; a_in_valid = 1; a_in_inv = 0; a_in_data = VecIn; a_out_ready = 1;
    b_flush = 0; b_in_valid = 0; b_in_inv = 0; b_in_data = '0; b_out_ready = 1;

    // Reset state.
    #1 rst_n = 0;
    #1;
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out_data", a_out_data, 0);
    check("rst_a_out_inv", a_out_inv, 0);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_out_data", b_out_data, 0);
    #1 rst_n = 1;
    check("a_in_ready_after_rst", a_in_ready, 1);

    // A: first edge after release accepts; output one cycle later.
    step();
    check("a_fwd_valid", a_out_valid, 1);
    check("a_fwd_data", a_out_data, VecOut);
    check("a_fwd_inv", a_out_inv, 0);
    a_in_data = VecOut; a_in_inv = 1;
    step();
    check("a_inv_valid", a_out_valid, 1);
    check("a_inv_data", a_out_data, VecIn);
    check("a_inv_inv", a_out_inv, 1);
    a_in_valid = 0;
    step();
    check("a_idle_valid", a_out_valid, 0);

    // B: NB=8 forward vector and inverse round trip.
    b_in_valid = 1; b_in_data = Asc; b_in_inv = 0;
    step();
    b_in_valid = 0;
    wait_b("b_fwd_wait");
    check("b_fwd_col0", b_out_data[255:224], 32'h00050e13);
    y = b_out_data;
    step();
    b_in_valid = 1; b_in_data = y; b_in_inv = 1;
    step();
    b_in_valid = 0;
    wait_b("b_rt_wait");
    check("b_roundtrip", b_out_data, Asc);
    check("b_roundtrip_inv", b_out_inv, 1);
    step();

    // B: ten back-to-back words, out_ready toggling every two cycles.
    for (int i = 0; i < 10; i++) words[i] = rnd256();
    rx_base = received; sent = 0; cyc = 0;
    while (sent < 10 && cyc < 200) begin
      b_out_ready = ((cyc / 2) % 2) == 0;
      b_in_valid = 1; b_in_data = words[sent]; b_in_inv = sent[0];
      #1 acc = b_in_ready;
      step();
      if (acc) sent++;
      cyc++;
    end
    b_in_valid = 0; b_out_ready = 1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("b_burst_count", received - rx_base, 10);
    check("b_burst_drained", sb.size(), 0);

    // B: fill with three stalled words, then flush.
    b_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1; b_in_data = rnd256(); b_in_inv = i[0];
      step();
    end
    check("b_full_in_ready", b_in_ready, 0);
    b_flush = 1; b_in_data = rnd256();
    #1 check("b_flush_in_ready", b_in_ready, 0);
    step();
    b_flush = 0; b_in_valid = 0;
    check("b_flush_out_valid", b_out_valid, 0);
    b_out_ready = 1; b_in_valid = 1; b_in_data = rnd256(); b_in_inv = 1;
    step();
    b_in_valid = 0;
    check("b_lat_c1", b_out_valid, 0);
    step();
    check("b_lat_c2", b_out_valid, 0);
    step();
    check("b_lat_c3", b_out_valid, 1);
    step();
    check("b_after_flush_empty", b_out_valid, 0);
    step();

    // B: reset pulse mid-stream, shorter than half a cycle.
    b_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1; b_in_data = rnd256(); b_in_inv = ~i[0];
      step();
    end
    b_in_valid = 0;
    check("b_pre_rst_valid", b_out_valid, 1);
    @(posedge clk);
    #2 rst_n = 0;
    sb.delete();
    #1;
    check("midrst_b_out_valid", b_out_valid, 0);
    check("midrst_b_out_data", b_out_data, 0);
    check("midrst_b_out_inv", b_out_inv, 0);
    check("midrst_a_out_valid", a_out_valid, 0);
    #1 rst_n = 1;
    check("midrst_b_in_ready", b_in_ready, 1);
    b_out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("b_no_stale", b_out_valid, 0);
    end
    b_in_valid = 1; b_in_data = Asc; b_in_inv = 0;
    step();
    b_in_valid = 0;
    wait_b("b_post_rst_wait");
    check("b_post_rst_col0", b_out_data[255:224], 32'h00050e13);
    repeat (4) step();
    check("b_final_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
